// File: rtl/simon_pkg.sv
// Shared types and constants for the parametrised Simon game.
package simon_pkg;

    typedef enum logic [1:0] {
        ST_INPUT    = 2'd0,
        ST_PLAYBACK = 2'd1,
        ST_REPEAT   = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam logic [2:0] MODE_INPUT    = 3'b001;
    localparam logic [2:0] MODE_PLAYBACK = 3'b010;
    localparam logic [2:0] MODE_REPEAT   = 3'b100;
    localparam logic [2:0] MODE_DONE     = 3'b111;

    localparam logic LEVEL_EASY = 1'b0;
    localparam logic LEVEL_HARD = 1'b1;

    function automatic logic [2:0] mode_of(input state_t st);
        logic [2:0] m;
        m = MODE_INPUT;
        case (st)
            ST_INPUT:    m = MODE_INPUT;
            ST_PLAYBACK: m = MODE_PLAYBACK;
            ST_REPEAT:   m = MODE_REPEAT;
            ST_DONE:     m = MODE_DONE;
            default:     m = MODE_INPUT;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/simon_seq_mem.sv
// Sequence storage: DEPTH x N registers, one synchronous write, one async read.
module simon_seq_mem #(
    parameter int unsigned N     = 4,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [N-1:0]  rdata
);

    logic [N-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/simon_game_param.sv
// Simon game top: pattern entry, paced playback, repeat checking, score and win.
module simon_game_param
    import simon_pkg::*;
#(
    parameter int unsigned N          = 4,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned PLAY_TICKS = 1
) (
    input  logic                       pclk,
    input  logic                       rst,
    input  logic                       level,
    input  logic [N-1:0]               pattern,
    input  logic                       pattern_vld,
    output logic [N-1:0]               pattern_leds,
    output logic [2:0]                 mode_leds,
    output logic [$clog2(DEPTH+1)-1:0] score,
    output logic                       win
);

    localparam int unsigned SW = $clog2(DEPTH + 1);
    localparam int unsigned TW = $clog2(PLAY_TICKS + 1);

    state_t        state_q, state_d;
    logic [SW-1:0] count_q, count_d;
    logic [SW-1:0] index_q, index_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [SW-1:0] score_d;
    logic          win_d;
    logic          lvl_q;
    logic          we;
    logic [N-1:0]  rdata;
    logic          legal;
    logic          last_tick;
    logic          last_idx;

    simon_seq_mem #(.N(N), .DEPTH(DEPTH), .AW(SW)) u_mem (
        .clk   (pclk),
        .we    (we),
        .waddr (count_q),
        .wdata (pattern),
        .raddr (index_q),
        .rdata (rdata)
    );

    assign legal     = (lvl_q == LEVEL_HARD) ? (|pattern) : $onehot(pattern);
    assign last_tick = (tick_q == TW'(PLAY_TICKS - 1));
    assign last_idx  = (index_q == count_q - SW'(1));

    // State and datapath registers; level is captured only during reset
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q   <= ST_INPUT;
            count_q   <= '0;
            index_q   <= '0;
            tick_q    <= '0;
            score     <= '0;
            win       <= 1'b0;
            lvl_q     <= level;
            mode_leds <= MODE_INPUT;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            index_q   <= index_d;
            tick_q    <= tick_d;
            score     <= score_d;
            win       <= win_d;
            mode_leds <= mode_of(state_d);
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        tick_d  = tick_q;
        score_d = score;
        win_d   = win;
        we      = 1'b0;
        case (state_q)
            ST_INPUT: begin
                if (pattern_vld && legal) begin
                    we      = 1'b1;
                    count_d = count_q + SW'(1);
                    index_d = '0;
                    tick_d  = '0;
                    state_d = ST_PLAYBACK;
                end
            end
            ST_PLAYBACK, ST_DONE: begin
                tick_d = tick_q + TW'(1);
                if (last_tick) begin
                    tick_d  = '0;
                    index_d = index_q + SW'(1);
                    if (last_idx) begin
                        index_d = '0;
                        if (state_q == ST_PLAYBACK) begin
                            state_d = ST_REPEAT;
                        end
                    end
                end
            end
            ST_REPEAT: begin
                if (pattern_vld) begin
                    if (pattern != rdata) begin
                        state_d = ST_DONE;
                        win_d   = 1'b0;
                        index_d = '0;
                        tick_d  = '0;
                    end else if (!last_idx) begin
                        index_d = index_q + SW'(1);
                    end else begin
                        score_d = score + SW'(1);
                        if (count_q == SW'(DEPTH)) begin
                            state_d = ST_DONE;
                            win_d   = 1'b1;
                            index_d = '0;
                            tick_d  = '0;
                        end else begin
                            state_d = ST_INPUT;
                        end
                    end
                end
            end
            default: state_d = ST_INPUT;
        endcase
    end

    // Echo the pads while the player drives them, otherwise show the stored entry
    always_comb begin
        pattern_leds = pattern;
        if (state_q == ST_PLAYBACK || state_q == ST_DONE) begin
            pattern_leds = rdata;
        end
    end

endmodule

// File: tb/tb_simon_game_param.sv
// Randomised scoreboard bench for simon_game_param against a game-level model.
module tb_simon_game_param;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int PT = 2;

    localparam int P_INPUT = 0;
    localparam int P_PLAY  = 1;
    localparam int P_REP   = 2;
    localparam int P_DONE  = 3;

    typedef struct packed {
        logic [2:0] mode;
        logic [3:0] leds;
        logic [2:0] score;
        logic       win;
    } exp_t;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic       level = 1'b0;
    logic [3:0] pattern = '0;
    logic       pattern_vld = 1'b0;
    logic [3:0] pattern_leds;
    logic [2:0] mode_leds;
    logic [2:0] score;
    logic       win;

    simon_game_param #(.N(N), .DEPTH(D), .PLAY_TICKS(PT)) dut (
        .pclk         (pclk),
        .rst          (rst),
        .level        (level),
        .pattern      (pattern),
        .pattern_vld  (pattern_vld),
        .pattern_leds (pattern_leds),
        .mode_leds    (mode_leds),
        .score        (score),
        .win          (win)
    );

    always #5 pclk = ~pclk;

    // Game-level reference model
    int         m_phase = P_INPUT;
    logic [3:0] m_seq[$];
    int         m_el = 0;
    int         m_rep = 0;
    int         m_score = 0;
    bit         m_win = 1'b0;
    bit         m_lvl = 1'b0;
    bit         started = 1'b0;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;

    function automatic bit is_legal(input bit lvl, input logic [3:0] p);
        if (lvl) return p != 4'd0;
        return $countones(p) == 1;
    endfunction

    task automatic model_update(input bit r, input bit l, input logic [3:0] p, input bit v);
        if (r) begin
            m_phase = P_INPUT;
            m_seq.delete();
            m_score = 0;
            m_win = 1'b0;
            m_lvl = l;
        end else begin
            case (m_phase)
                P_INPUT: if (v && is_legal(m_lvl, p)) begin
                    m_seq.push_back(p);
                    m_phase = P_PLAY;
                    m_el = 0;
                end
                P_PLAY: begin
                    m_el++;
                    if (m_el == m_seq.size() * PT) begin
                        m_phase = P_REP;
                        m_rep = 0;
                    end
                end
                P_REP: if (v) begin
                    if (p != m_seq[m_rep]) begin
                        m_phase = P_DONE;
                        m_win = 1'b0;
                        m_el = 0;
                    end else if (m_rep == m_seq.size() - 1) begin
                        m_score++;
                        if (m_seq.size() == D) begin
                            m_phase = P_DONE;
                            m_win = 1'b1;
                            m_el = 0;
                        end else begin
                            m_phase = P_INPUT;
                        end
                    end else begin
                        m_rep++;
                    end
                end
                default: m_el++;
            endcase
        end
    endtask

    function automatic exp_t model_out(input logic [3:0] p);
        exp_t e;
        e.score = 3'(m_score);
        e.win   = m_win;
        e.leds  = p;
        case (m_phase)
            P_INPUT: e.mode = 3'b001;
            P_PLAY: begin
                e.mode = 3'b010;
                e.leds = m_seq[m_el / PT];
            end
            P_REP:   e.mode = 3'b100;
            default: begin
                e.mode = 3'b111;
                e.leds = m_seq[(m_el / PT) % m_seq.size()];
            end
        endcase
        return e;
    endfunction

    // One clock cycle: apply inputs, queue the expected view, advance the model
    task automatic step(input bit r, input bit l, input logic [3:0] p, input bit v);
        rst = r;
        level = l;
        pattern = p;
        pattern_vld = v;
        if (started) exp_q.push_back(model_out(p));
        @(posedge pclk);
        model_update(r, l, p, v);
        started = 1'b1;
        #1;
    endtask

    // Monitor: every mid-cycle, compare DUT outputs to the queued expectation
    always @(negedge pclk) begin
        cyc++;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (mode_leds === e.mode && pattern_leds === e.leds &&
                score === e.score && win === e.win) begin
                n_pass++;
            end else begin
                $display("FAIL outputs cycle %0d: mode/leds/score/win got %b/%b/%0d/%b want %b/%b/%0d/%b",
                         cyc, mode_leds, pattern_leds, score, win, e.mode, e.leds, e.score, e.win);
            end
        end
    end

    // Registered outputs right after a reset edge
    task automatic chk_reset();
        n_checks++;
        if (mode_leds === 3'b001 && score === 3'd0 && win === 1'b0) begin
            n_pass++;
        end else begin
            $display("FAIL reset state: mode/score/win got %b/%0d/%b want 001/0/0",
                     mode_leds, score, win);
        end
    endtask

    // A perfect game must reach DONE with a win before its cycle budget expires
    task automatic chk_done();
        n_checks++;
        if (m_phase == P_DONE && mode_leds === 3'b111 && win === 1'b1 &&
            score === 3'(D)) begin
            n_pass++;
        end else begin
            $display("FAIL perfect game timed out or ended wrong: mode/score/win got %b/%0d/%b",
                     mode_leds, score, win);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'($urandom), 1'b0);
    endtask

    task automatic game(input bit lvl, input int correct_pct, input bit allow_rst);
        logic [3:0] p;
        bit         v;
        bit         r;
        step(1'b1, lvl, 4'($urandom), 1'b0);
        for (int c = 0; c < 400 && m_phase != P_DONE; c++) begin
            p = 4'($urandom);
            v = ($urandom_range(0, 2) == 0);
            if (m_phase == P_INPUT && $urandom_range(0, 3) != 0)
                p = lvl ? 4'($urandom_range(1, 15)) : 4'(1 << $urandom_range(0, 3));
            if (m_phase == P_REP && v && $urandom_range(1, 100) <= correct_pct)
                p = m_seq[m_rep];
            r = allow_rst && ($urandom_range(0, 149) == 0);
            step(r, 1'($urandom), p, v);
        end
        if (correct_pct == 100 && !allow_rst) chk_done();
        for (int i = 0; i < 10; i++) step(1'b0, 1'($urandom), 4'($urandom), 1'($urandom));
    endtask

    initial begin
        // Directed opening: illegal then legal entry, ignored strobes, failing repeat
        step(1'b1, 1'b0, 4'b0000, 1'b0);
        chk_reset();
        step(1'b0, 1'b0, 4'b0011, 1'b1);
        step(1'b0, 1'b0, 4'b0000, 1'b0);
        step(1'b0, 1'b0, 4'b0100, 1'b1);
        step(1'b0, 1'b1, 4'b1111, 1'b1);
        step(1'b0, 1'b0, 4'b0000, 1'b0);
        step(1'b0, 1'b0, 4'b0100, 1'b1);
        step(1'b0, 1'b0, 4'b0001, 1'b1);
        step(1'b0, 1'b0, 4'b0010, 1'b1);
        idle(4);
        step(1'b0, 1'b0, 4'b0100, 1'b1);
        step(1'b0, 1'b0, 4'b0100, 1'b1);
        idle(8);
        // Hard level: multi-bit entry accepted, reset mid-playback
        step(1'b1, 1'b1, 4'b0000, 1'b0);
        chk_reset();
        step(1'b0, 1'b0, 4'b0000, 1'b1);
        step(1'b0, 1'b0, 4'b1011, 1'b1);
        step(1'b0, 1'b0, 4'b0000, 1'b0);
        step(1'b1, 1'b0, 4'b0000, 1'b0);
        chk_reset();
        idle(3);
        // Perfect games to full depth, then random play with occasional resets
        game(1'b0, 100, 1'b0);
        game(1'b1, 100, 1'b0);
        for (int g = 0; g < 12; g++) game(1'($urandom), 85, 1'b1);
        idle(2);
        @(negedge pclk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
